// File: rtl/tqvp_uart_pkg.sv
// Shared definitions for the tqvp UART receiver.
// Holds the receiver FSM state encoding, the parity_mode and data_bits
// codes, and small decode helpers used by the receiver top level.
package tqvp_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_e;

  // parity_mode codes; 11 is a second encoding of "no parity"
  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  // data_bits codes
  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  // Index of the last data bit of a frame (4..7)
  function automatic logic [2:0] last_bit_idx(input logic [1:0] db);
    return 3'd4 + {1'b0, db};
  endfunction

  function automatic logic parity_enabled(input logic [1:0] pm);
    return (pm == PAR_EVEN) || (pm == PAR_ODD);
  endfunction

endpackage

// File: rtl/tqvp_uart_sync_fifo.sv
// Single-clock FIFO for received UART entries.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   push, push_data write request and entry; ignored when full unless a
//                   pop happens in the same cycle
//   pop             read request; ignored when empty
//   head_data       entry at the read pointer, read combinationally
//   full, empty     occupancy flags
//   level           number of stored entries (0..DEPTH)
module tqvp_uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign head_data = mem[rd_ptr_q];

  // A pop frees the slot the same cycle, so a full FIFO still accepts a push
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) level_d = level_q + LW'(1);
    else if (do_pop && !do_push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; level gates whether contents are visible
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/tqvp_uart_rx2.sv
// UART receiver with a small receive FIFO.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   uart_rxd          asynchronous serial input, idle high
//   uart_rts          registered request-to-send, low = ready for data
//   data_bits         5..8 data bits, parity_mode none/even/odd, two_stop
//                     (latched at each start bit)
//   baud_divider      bit period is baud_divider+1 clocks
//   rx_read           pop the head entry
//   rx_valid, rx_data, rx_parity_err, rx_frame_err  head entry view
//   rx_level          FIFO occupancy
//   rx_overrun        sticky dropped-frame flag, cleared by overrun_clear
module tqvp_uart_rx2
  import tqvp_uart_pkg::*;
#(
  parameter int COUNT_REG_LEN = 13,
  parameter int FIFO_DEPTH    = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uart_rxd,
  output logic                     uart_rts,
  input  logic [1:0]               data_bits,
  input  logic [1:0]               parity_mode,
  input  logic                     two_stop,
  input  logic [COUNT_REG_LEN-1:0] baud_divider,
  input  logic                     rx_read,
  output logic                     rx_valid,
  output logic [7:0]               rx_data,
  output logic                     rx_parity_err,
  output logic                     rx_frame_err,
  output logic [LW-1:0]            rx_level,
  output logic                     rx_overrun,
  input  logic                     overrun_clear
);

  logic                     rxd_meta_q, rxd_s_q;
  rx_state_e                state_q, state_d;
  logic [COUNT_REG_LEN-1:0] cnt_q, cnt_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic [7:0]               shift_q, shift_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic [1:0]               cfg_bits_q, cfg_bits_d;
  logic [1:0]               cfg_par_q, cfg_par_d;
  logic                     cfg_two_q, cfg_two_d;
  logic                     overrun_q, overrun_d;
  logic                     rts_q, rts_d;

  logic                     next_bit, mid_bit, par_x;
  logic                     push;
  logic [9:0]               push_data, head_data;
  logic                     fifo_full, fifo_empty;

  assign next_bit = (cnt_q >= baud_divider);
  assign mid_bit  = (cnt_q == (baud_divider >> 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + COUNT_REG_LEN'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    cfg_bits_d = cfg_bits_q;
    cfg_par_d  = cfg_par_q;
    cfg_two_d  = cfg_two_q;
    push       = 1'b0;
    par_x      = ^shift_q ^ rxd_s_q;

    if (state_q == ST_IDLE || next_bit) cnt_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (!rxd_s_q) begin
          state_d    = ST_START;
          cfg_bits_d = data_bits;
          cfg_par_d  = parity_mode;
          cfg_two_d  = two_stop;
          bit_idx_d  = '0;
          shift_d    = '0;   // keeps unused MSBs zero for short frames
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      ST_START: begin
        // Line back high at mid start bit: treat as a glitch
        if (mid_bit && rxd_s_q) state_d = ST_IDLE;
        else if (next_bit)      state_d = ST_DATA;
      end
      ST_DATA: begin
        if (mid_bit) shift_d[bit_idx_q] = rxd_s_q;
        if (next_bit) begin
          if (bit_idx_q == last_bit_idx(cfg_bits_q))
            state_d = parity_enabled(cfg_par_q) ? ST_PARITY : ST_STOP1;
          else
            bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (mid_bit) perr_d = (cfg_par_q == PAR_EVEN) ? par_x : !par_x;
        if (next_bit) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        if (mid_bit) begin
          ferr_d = !rxd_s_q;
          if (!cfg_two_q) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        if (cfg_two_q && next_bit) state_d = ST_STOP2;
      end
      ST_STOP2: begin
        if (mid_bit) begin
          ferr_d  = ferr_q | !rxd_s_q;
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // ferr_d already includes the stop bit sampled this cycle
    push_data = {shift_q, perr_q, ferr_d};
  end

  tqvp_uart_sync_fifo #(
    .WIDTH(10),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (rx_read),
    .head_data(head_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (rx_level)
  );

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clear) overrun_d = 1'b0;
    // A frame lost this cycle outranks a clear
    if (push && fifo_full && !(rx_read && !fifo_empty)) overrun_d = 1'b1;
    rts_d = (rx_level >= LW'(FIFO_DEPTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      cfg_bits_q <= DBITS_8;
      cfg_par_q  <= PAR_NONE;
      cfg_two_q  <= 1'b0;
      overrun_q  <= 1'b0;
      rts_q      <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      cfg_bits_q <= cfg_bits_d;
      cfg_par_q  <= cfg_par_d;
      cfg_two_q  <= cfg_two_d;
      overrun_q  <= overrun_d;
      rts_q      <= rts_d;
    end
  end

  assign uart_rts      = rts_q;
  assign rx_valid      = !fifo_empty;
  assign rx_data       = head_data[9:2];
  assign rx_parity_err = head_data[1];
  assign rx_frame_err  = head_data[0];
  assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_tqvp_uart_rx2.sv
// Directed bench for tqvp_uart_rx2 at baud_divider=7 (8 clocks per bit).
module tb_tqvp_uart_rx2;
  import tqvp_uart_pkg::*;

  localparam int BP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rxd;
  logic        uart_rts;
  logic [1:0]  data_bits;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic [12:0] baud_divider;
  logic        rx_read;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_parity_err;
  logic        rx_frame_err;
  logic [2:0]  rx_level;
  logic        rx_overrun;
  logic        overrun_clear;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tqvp_uart_rx2 dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rxd     (uart_rxd),
    .uart_rts     (uart_rts),
    .data_bits    (data_bits),
    .parity_mode  (parity_mode),
    .two_stop     (two_stop),
    .baud_divider (baud_divider),
    .rx_read      (rx_read),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_level     (rx_level),
    .rx_overrun   (rx_overrun),
    .overrun_clear(overrun_clear)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
    $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic line_bit(input logic v, input int clocks);
    uart_rxd = v;
    tick(clocks);
  endtask

  // Start bit, LSB-first data, optional parity, stop bit(s), then idle.
  // A low second stop bit is held 5 clocks so it covers the mid-bit sample
  // but is high again before the receiver looks for the next start bit.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit par_en,
                            input bit par_bit, input bit two, input bit stop2_low);
    line_bit(1'b0, BP);
    for (int i = 0; i < nb; i++) line_bit(d[i], BP);
    if (par_en) line_bit(par_bit, BP);
    line_bit(1'b1, BP);
    if (two) begin
      if (stop2_low) begin
        line_bit(1'b0, 5);
        line_bit(1'b1, 3);
      end else begin
        line_bit(1'b1, BP);
      end
    end
    line_bit(1'b1, 2 * BP);
  endtask

  task automatic pop1();
    rx_read = 1'b1;
    tick(1);
    rx_read = 1'b0;
  endtask

  initial begin
    logic [7:0] b;

    rst           = 1'b1;
    uart_rxd      = 1'b1;
    data_bits     = DBITS_8;
    parity_mode   = PAR_NONE;
    two_stop      = 1'b0;
    baud_divider  = 13'd7;
    rx_read       = 1'b0;
    overrun_clear = 1'b0;
    tick(4);

    // Reset state
    chk("rst_valid", rx_valid, 0);
    chk("rst_level", rx_level, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_rts", uart_rts, 1);
    chk("rst_state", dut.state_q, ST_IDLE);
    rst = 1'b0;
    tick(3);
    chk("idle_rts", uart_rts, 0);

    // 8N1 byte 0xA5
    send_frame(8'hA5, 8, 0, 0, 0, 0);
    chk("a5_valid", rx_valid, 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_perr", rx_parity_err, 0);
    chk("a5_ferr", rx_frame_err, 0);
    chk("a5_rts", uart_rts, 0);
    chk("a5_level", rx_level, 1);
    pop1();
    chk("a5_pop_valid", rx_valid, 0);

    // 5 data bits, even parity: 0x15 has three ones, correct parity bit is 1
    data_bits   = DBITS_5;
    parity_mode = PAR_EVEN;
    send_frame(8'h15, 5, 1, 1, 0, 0);
    chk("p5_ok_data", rx_data, 8'h15);
    chk("p5_ok_perr", rx_parity_err, 0);
    chk("p5_ok_ferr", rx_frame_err, 0);
    pop1();
    send_frame(8'h15, 5, 1, 0, 0, 0);
    chk("p5_bad_valid", rx_valid, 1);
    chk("p5_bad_data", rx_data, 8'h15);
    chk("p5_bad_perr", rx_parity_err, 1);
    pop1();

    // Two stop bits, second one low
    data_bits   = DBITS_8;
    parity_mode = PAR_NONE;
    two_stop    = 1'b1;
    send_frame(8'h5A, 8, 0, 0, 1, 1);
    chk("s2_valid", rx_valid, 1);
    chk("s2_data", rx_data, 8'h5A);
    chk("s2_ferr", rx_frame_err, 1);
    chk("s2_perr", rx_parity_err, 0);
    chk("s2_level", rx_level, 1);
    pop1();
    two_stop = 1'b0;

    // 2-clock glitch on idle line
    line_bit(1'b0, 2);
    line_bit(1'b1, 3 * BP);
    chk("gl_level", rx_level, 0);
    chk("gl_valid", rx_valid, 0);
    chk("gl_state", dut.state_q, ST_IDLE);

    // Five frames, no reads
    for (int k = 0; k < 5; k++) begin
      b = 8'h11 * 8'(k + 1);
      send_frame(b, 8, 0, 0, 0, 0);
      if (k == 2) begin
        chk("ov3_rts", uart_rts, 1);
        chk("ov3_level", rx_level, 3);
      end
      if (k == 3) begin
        chk("ov4_overrun", rx_overrun, 0);
        chk("ov4_level", rx_level, 4);
      end
    end
    chk("ov5_level", rx_level, 4);
    chk("ov5_overrun", rx_overrun, 1);
    chk("ov5_rts", uart_rts, 1);
    for (int k = 0; k < 4; k++) begin
      b = 8'h11 * 8'(k + 1);
      chk($sformatf("ov_read%0d", k), rx_data, b);
      pop1();
    end
    chk("ov_empty", rx_valid, 0);
    chk("ov_sticky", rx_overrun, 1);
    overrun_clear = 1'b1;
    tick(1);
    overrun_clear = 1'b0;
    chk("ov_clear", rx_overrun, 0);

    // Reset in the middle of a frame, then a full 0x3C frame
    line_bit(1'b0, BP);
    line_bit(1'b0, BP);
    line_bit(1'b0, BP);
    line_bit(1'b1, 3);
    rst      = 1'b1;
    uart_rxd = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(BP);
    chk("mr_after_rst_level", rx_level, 0);
    send_frame(8'h3C, 8, 0, 0, 0, 0);
    chk("mr_level", rx_level, 1);
    chk("mr_data", rx_data, 8'h3C);
    chk("mr_ferr", rx_frame_err, 0);
    pop1();
    chk("mr_pop_level", rx_level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tqvp_uart_rx2.md
TQVP_UART_RX2 -- requirements
Module: tqvp_uart_rx2

Interface
REQ-001 SHALL have parameter COUNT_REG_LEN, default 13, meaning width of the baud counter and baud_divider.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries; power of two, 2..16.
REQ-003 SHALL have ports in this order:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- uart_rxd  input  1  serial receive line, asynchronous, idle high.
- uart_rts  output  1  request-to-send, active low.
- data_bits  input  2  frame width: 00=5, 01=6, 10=7, 11=8.
- parity_mode  input  2  00=none, 01=even, 10=odd, 11=none.
- two_stop  input  1  1 = check two stop bits.
- baud_divider  input  COUNT_REG_LEN  bit period is baud_divider+1 clocks.
- rx_read  input  1  pop head entry.
- rx_valid  output  1  FIFO not empty.
- rx_data  output  8  head data, right-aligned, unused MSBs zero.
- rx_parity_err  output  1  head entry parity error.
- rx_frame_err  output  1  head entry stop-bit error.
- rx_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- rx_overrun  output  1  sticky overrun flag.
- overrun_clear  input  1  clears rx_overrun.

Function
REQ-004 SHALL pass uart_rxd through a 2-flop synchroniser; all decoding uses the synchronised value (rxd_s).
REQ-005 SHALL count baud cycles: counter clears in IDLE and when counter >= baud_divider (next_bit), else increments; mid_bit = counter == baud_divider>>1.
REQ-006 SHALL use FSM states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-007 SHALL move IDLE->START when rxd_s==0, latching data_bits, parity_mode and two_stop for the whole frame; later changes affect only the next frame.
REQ-008 SHALL, in START at mid_bit, return to IDLE if rxd_s==1 (glitch reject, nothing pushed), else continue; START->DATA on next_bit.
REQ-009 SHALL sample each data bit at mid_bit, shifting LSB-first; DATA exits on next_bit after the latched bit count to PARITY (if parity enabled) or STOP1.
REQ-010 SHALL, in PARITY, sample at mid_bit; error if XOR(data, parity bit) is 1 for even or 0 for odd; exit on next_bit.
REQ-011 SHALL, in STOP1, sample at mid_bit; rxd_s==0 sets frame error; go to STOP2 at next_bit if two_stop, else push and go to IDLE at that mid_bit.
REQ-012 SHALL, in STOP2, sample at mid_bit, OR into frame error, push and go to IDLE at that mid_bit.
REQ-013 SHALL push {data, parity_err, frame_err} for frames with errors as well as clean ones.
REQ-014 SHALL assert rx_valid/rx_data the cycle after the push (1-cycle latency); outputs show the head entry combinationally from FIFO storage.
REQ-015 SHALL pop on rx_read && rx_valid; rx_read when empty is ignored.
REQ-016 SHALL, on a push when full without a same-cycle pop, drop the frame, keep FIFO contents and set rx_overrun.
REQ-017 SHALL, on a same-cycle push and pop when full, perform both with no overrun and rx_level unchanged.
REQ-018 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-019 SHALL clear rx_overrun on overrun_clear; a simultaneous new overrun wins (flag stays 1).
REQ-020 SHALL register uart_rts = 1 when rx_level >= FIFO_DEPTH-1, else 0.

Reset
REQ-021 SHALL, on rst, go to IDLE, clear the counter and FIFO pointers, set rx_level=0, rx_valid=0, rx_overrun=0, and set uart_rts=1 and synchroniser flops to 1.
REQ-022 SHALL discard any partially received frame when rst is asserted mid-frame; FIFO data storage need not be reset.

Structure
REQ-023 SHALL hold FSM state encodings, parity_mode and data_bits constants in shared package tqvp_uart_pkg.
REQ-024 SHALL implement the FIFO as sub-module tqvp_uart_sync_fifo, parametrised by width and depth, with push, pop, full, empty and level.

Verification
REQ-025 SHALL test baud_divider=7, 8N1, byte 0xA5 -> rx_valid=1, rx_data=0xA5, both error flags 0, uart_rts=0.
REQ-026 SHALL test 5 data bits with even parity, data 0x15 and a correct parity bit -> rx_data=0x15; then a wrong parity bit -> rx_parity_err=1.
REQ-027 SHALL test two_stop=1 with the second stop bit driven low -> rx_frame_err=1 and data still pushed.
REQ-028 SHALL test a low pulse of 2 clocks on idle rxd -> no push, FSM back in IDLE.
REQ-029 SHALL test FIFO_DEPTH=4 with 5 frames and no reads -> rx_level=4, rx_overrun=1, uart_rts=1 after the 3rd frame, and reads return the first 4 bytes in order.
REQ-030 SHALL test rst asserted mid-frame, then a full frame 0x3C -> only 0x3C is received, rx_level=1.
